// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: FSM state codes, next-PC select codes, reset PC.
// Lives alongside ctrl_encode_def.v so decoder and fetch agree on encodings.
package instr_fetch_pkg;

    localparam logic [1:0] IF_IDLE  = 2'd0;
    localparam logic [1:0] IF_REQ   = 2'd1;
    localparam logic [1:0] IF_VALID = 2'd2;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/instr_fetch_npc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats pc+4.
module instr_fetch_npc_calc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] npc,
    output logic [1:0]  sel
);

    logic [31:0] pc4;
    logic [31:0] boff;
    logic        unused_ir_hi;

    assign pc4          = pc + 32'd4;
    assign boff         = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign unused_ir_hi = ^ir[31:26];

    always_comb begin
        npc = pc4;
        sel = NPC_PLUS4;
        if (jump) begin
            npc = {pc4[31:28], ir[25:0], 2'b00};
            sel = NPC_JUMP;
        end else if (branch && zero) begin
            npc = pc4 + boff;
            sel = NPC_BRANCH;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC and IR, fetches from imem, redirects on jump/branch.
// Define IF_DELAY_SLOT_EN for MIPS-style single branch delay slot.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      imem,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    output logic [31:0]        pc,
    output logic [31:0]        ir,
    output logic [5:0]         opcode,
    output logic [5:0]         funct
);

    logic [1:0]  state;
    logic [31:0] npc;
    logic [1:0]  sel;
    logic        accept;

    assign accept         = (state == IF_VALID) && instr_ready;
    assign instr_valid    = (state == IF_VALID);
    assign imem.imem_req  = (state == IF_REQ);
    assign imem.imem_addr = pc;
    assign opcode         = ir[31:26];
    assign funct          = ir[5:0];

    instr_fetch_npc_calc u_npc (
        .pc     (pc),
        .ir     (ir),
        .jump   (jump),
        .branch (branch),
        .zero   (zero),
        .npc    (npc),
        .sel    (sel)
    );

    // Async reset also kills an in-flight request; the response is simply never sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IF_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                IF_IDLE:  state <= IF_REQ;
                IF_REQ: begin
                    if (imem.imem_ready) begin
                        ir    <= imem.imem_rdata;
                        state <= IF_VALID;
                    end
                end
                IF_VALID: if (instr_ready) state <= IF_REQ;
                default:  state <= IF_IDLE;
            endcase
        end
    end

`ifdef IF_DELAY_SLOT_EN
    logic        pend;
    logic [31:0] pend_tgt;

    // While a redirect is pending, the slot instruction's own jump/branch is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            pend     <= 1'b0;
            pend_tgt <= '0;
        end else if (accept) begin
            if (pend) begin
                pc   <= pend_tgt;
                pend <= 1'b0;
            end else if (sel != NPC_PLUS4) begin
                pend_tgt <= npc;
                pend     <= 1'b1;
                pc       <= pc + 32'd4;
            end else begin
                pc <= npc;
            end
        end
    end
`else
    logic unused_sel;
    assign unused_sel = ^sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (accept)
            pc <= npc;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level reference model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        instr_ready, jump, branch, zero;
    logic        instr_valid;
    logic [31:0] pc, ir;
    logic [5:0]  opcode, funct;
    logic        stall;
    logic [31:0] rom [0:63];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .funct       (funct)
    );

    // Memory: window 0x3000..0x30FC, zero-wait unless stalled; ready is not gated by req.
    assign bus.imem_rdata = (bus.imem_addr[31:8] == 24'h000030) ? rom[bus.imem_addr[7:2]] : 32'h0;
    assign bus.imem_ready = !stall;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a[31:8] == 24'h000030) ? rom[a[7:2]] : 32'h0;
    endfunction

    // Reference model: phase 0 = idle, 1 = requesting, 2 = holding an instruction.
    logic [31:0] m_pc  = RST_PC;
    logic [31:0] m_ir  = '0;
    logic [31:0] m_tgt = '0;
    bit          m_pend = 0;
    int          m_ph  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_ir = '0; m_ph = 0; m_pend = 0;
        end else begin
            case (m_ph)
                0: m_ph = 1;
                1: if (!stall) begin m_ir = rd(m_pc); m_ph = 2; end
                default: if (instr_ready) begin
                    logic [31:0] pc4, off, t;
                    bit taken;
                    pc4   = m_pc + 32'd4;
                    off   = 32'(int'($signed(m_ir[15:0])) * 4);
                    taken = jump || (branch && zero);
                    t     = jump ? ((pc4 & 32'hF000_0000) | (32'(m_ir[25:0]) * 4)) : pc4 + off;
`ifdef IF_DELAY_SLOT_EN
                    if (m_pend) begin m_pc = m_tgt; m_pend = 0; end
                    else if (taken) begin m_tgt = t; m_pend = 1; m_pc = pc4; end
                    else m_pc = pc4;
`else
                    m_pc = taken ? t : pc4;
`endif
                    m_ph = 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("req",    {31'd0, bus.imem_req}, {31'd0, m_ph == 1});
            chk("addr",   bus.imem_addr, m_pc);
            chk("pc",     pc, m_pc);
            chk("valid",  {31'd0, instr_valid}, {31'd0, m_ph == 2});
            chk("ir",     ir, m_ir);
            chk("opcode", {26'd0, opcode}, {26'd0, m_ir[31:26]});
            chk("funct",  {26'd0, funct}, {26'd0, m_ir[5:0]});
        end
    end

    // Returns at the negedge where a fetch handshake completes (current edge included).
    task automatic wait_fetch(output logic [31:0] a, output int c);
        a = 'x; c = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.imem_req && bus.imem_ready) begin
                a = bus.imem_addr; c = cyc; return;
            end
            @(negedge clk);
        end
        chk("fetch_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge in VALID; accepts, waits for next fetch, returns in VALID.
    task automatic accept(input logic j, b, z, output logic [31:0] a);
        int c;
        instr_ready = 1; jump = j; branch = b; zero = z;
        @(negedge clk);
        instr_ready = 0; jump = 0; branch = 0; zero = 0;
        wait_fetch(a, c);
        @(negedge clk);
    endtask

    logic [31:0] a0, a1, a2, a;
    int c0, c1, c2;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = 32'h3402_0005;
        rom[2] = 32'h2008_0001;
`ifdef IF_DELAY_SLOT_EN
        rom[4] = 32'h1000_0004;
`else
        rom[4] = 32'h1000_FFFC;
`endif
        rom[8] = 32'h0800_0C10;
        stall = 0; instr_ready = 0; jump = 0; branch = 0; zero = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc, 32'h0000_3000);
        chk("rst_ir",    ir, 32'h0);
        rst_n = 1; cmp_en = 1;

        // Zero-wait streaming with instr_ready held high.
        instr_ready = 1;
        wait_fetch(a0, c0);
        @(negedge clk);
        chk("ori_ir",     ir, 32'h3402_0005);
        chk("ori_opcode", {26'd0, opcode}, 32'h0000_000D);
        wait_fetch(a1, c1);
        @(negedge clk);
        wait_fetch(a2, c2);
        instr_ready = 0;
        chk("fetch0", a0, 32'h3000);
        chk("fetch1", a1, 32'h3004);
        chk("fetch2", a2, 32'h3008);
        chk("period01", 32'(c1 - c0), 32'd2);
        chk("period12", 32'(c2 - c1), 32'd2);

        // Backpressure: hold in VALID for five cycles.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_pc",    pc, 32'h3008);
            chk("bp_ir",    ir, 32'h2008_0001);
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_req",   {31'd0, bus.imem_req}, 32'd0);
            @(negedge clk);
        end
        accept(0, 0, 0, a); chk("seq_300c", a, 32'h300C);
        accept(0, 0, 0, a); chk("seq_3010", a, 32'h3010);

`ifdef IF_DELAY_SLOT_EN
        accept(0, 1, 1, a); chk("ds_slot", a, 32'h3014);
        accept(0, 1, 1, a); chk("ds_target", a, 32'h3024);
`else
        accept(0, 1, 1, a); chk("beq_taken", a, 32'h3004);
        accept(0, 0, 0, a); accept(0, 0, 0, a); accept(0, 0, 0, a);
        chk("back_3010", a, 32'h3010);
        accept(0, 1, 0, a); chk("beq_not_taken", a, 32'h3014);
        accept(0, 0, 0, a); accept(0, 0, 0, a); accept(0, 0, 0, a);
        chk("at_3020", a, 32'h3020);
        accept(1, 1, 1, a); chk("jump_wins", a, 32'h3040);
`endif

        // Reset while a request is stalled in REQ.
        stall = 1; instr_ready = 1;
        @(negedge clk);
        instr_ready = 0;
        chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("arst_pc",    pc, 32'h0000_3000);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        wait_fetch(a, c0);
        chk("post_rst_addr", a, 32'h3000);
        @(negedge clk);
        chk("post_rst_ir", ir, 32'h3402_0005);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
